dprio_reg_responder: RTL

Simulation-side DPRIO responder that models the transceiver reconfiguration register space seen by a DPRIO initiator such as the calibration controller. It decodes 1-cycle read/write strobes, drives `dprio_busy` for a fixed access time, commits writes to a local register file, and returns read data on `dprio_datain`. It sits on the DPRIO bus opposite the initiator in ASE transceiver testbenches, in place of the hard DPRIO block.

---
 rtl/dprio_reg_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/dprio_reg_responder.sv
// DPRIO register-space responder: 2**ADDR_BITS x 16-bit register file behind a 1-cycle rd/wr strobe bus.
// Latency: dprio_busy high for BUSY_CYCLES clocks after acceptance; data/count/register update on the final edge.
// Backpressure: none; strobes arriving while busy are dropped and flagged on access_error.
module dprio_reg_responder #(
    parameter int          ADDR_BITS   = 4,
    parameter int          BUSY_CYCLES = 3,
    parameter logic [8:0]  QUAD_ID     = 9'd0,
    parameter logic [15:0] RESET_DATA  = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] dprio_addr,
    input  logic [15:0] dprio_dataout,
    input  logic        dprio_rden,
    input  logic        dprio_wren,
    input  logic [8:0]  quad_addr,
    output logic        dprio_busy,
    output logic [15:0] dprio_datain,
    output logic        access_error,
    output logic [15:0] txn_count
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [7:0]           cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [15:0]          wdata_q;
    logic                 write_q;
    logic                 in_range_q;
    logic [15:0]          regs [DEPTH];

    logic quad_hit, addr_ok, accept, complete, err_nxt;

    assign quad_hit   = (quad_addr == QUAD_ID);
    assign addr_ok    = (dprio_addr[15:ADDR_BITS] == '0);
    assign dprio_busy = (state == BUSY);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (quad_hit) begin
                    if (dprio_rden && dprio_wren) begin
                        err_nxt = 1'b1;
                    end else if (dprio_rden || dprio_wren) begin
                        accept    = 1'b1;
                        err_nxt   = !addr_ok;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // A strobe on the final edge is still dropped: acceptance needs busy low.
                if (quad_hit && (dprio_rden || dprio_wren)) begin
                    err_nxt = 1'b1;
                end
                if (cnt == 8'd1) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= 8'd0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            write_q      <= 1'b0;
            in_range_q   <= 1'b0;
            dprio_datain <= 16'h0000;
            access_error <= 1'b0;
            txn_count    <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_DATA;
            end
        end else begin
            access_error <= err_nxt;
            if (accept) begin
                cnt        <= 8'(BUSY_CYCLES);
                addr_q     <= dprio_addr[ADDR_BITS-1:0];
                wdata_q    <= dprio_dataout;
                write_q    <= dprio_wren;
                in_range_q <= addr_ok;
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
            if (complete) begin
                txn_count <= txn_count + 16'd1;
                if (write_q) begin
                    if (in_range_q) begin
                        regs[addr_q] <= wdata_q;
                    end
                end else begin
                    dprio_datain <= in_range_q ? regs[addr_q] : 16'h0000;
                end
            end
        end
    end

endmodule
